// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the 1x3 router ingress path
//
// Contents:
//   state_t       ingress FSM states (IDLE, LOAD, CHECK, DROP)
//   NUM_PORTS     number of output FIFOs
//   DATA_W        byte width of the stream
//   ADDR_INVALID  destination code that marks a packet to be discarded
//   LEN_MSB/LSB   payload length field position inside the header byte
//   port_onehot   destination address to one-hot FIFO write strobe
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int DATA_W    = 8;
    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int LEN_MSB   = 7;
    localparam int LEN_LSB   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DROP  = 2'd3
    } state_t;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] addr);
        case (addr)
            2'd0:    port_onehot = 3'b001;
            2'd1:    port_onehot = 3'b010;
            2'd2:    port_onehot = 3'b100;
            default: port_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/router_parity.sv
// rtl/router_parity.sv - running XOR parity of one packet with compare output
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clear         zero the accumulator
//   seed          load the accumulator with data_in (header byte)
//   accumulate    XOR data_in into the accumulator (payload bytes)
//   data_in       byte being seeded, accumulated or compared
//   mismatch      data_in differs from the accumulated parity
module router_parity
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              seed,
    input  logic              accumulate,
    input  logic [DATA_W-1:0] data_in,
    output logic              mismatch
);

    logic [DATA_W-1:0] parity;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            parity <= '0;
        end else if (seed) begin
            parity <= data_in;
        end else if (accumulate) begin
            parity <= parity ^ data_in;
        end
    end

    assign mismatch = (data_in != parity);

endmodule

// File: rtl/router_ingress_ctrl.sv
// rtl/router_ingress_ctrl.sv - router ingress: header decode, FIFO write, back-pressure, parity
//
// Optional feature macro: ROUTER_PARITY_CHECK_EN (parity check and err; err tied 0 without it)
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   pkt_valid     source byte valid
//   data_in       source byte
//   fifo_full     per-FIFO full flags
//   fifo_empty    per-FIFO empty flags
//   busy          back-pressure; a byte is taken when pkt_valid && !busy
//   write_enb     one-hot FIFO write strobe (registered)
//   data_out      byte to the FIFOs (registered)
//   lfd_state     header marker, high in the cycle a valid header is taken
//   err           parity error of the last packet (registered)
module router_ingress_ctrl
    import router_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic [DATA_W-1:0]    data_out,
    output logic                 lfd_state,
    output logic                 err
);

    state_t     state, state_nxt;
    logic [1:0] addr;
    logic [6:0] cnt;

    // Padded flag vectors so address 3 can be used as an index safely:
    // it reads "not full" and "empty", which never blocks.
    logic [3:0] full_pad;
    logic [3:0] empty_pad;
    assign full_pad  = {1'b0, fifo_full};
    assign empty_pad = {1'b1, fifo_empty};

    logic [1:0] hdr_addr;
    logic [6:0] hdr_cnt;
    logic       hdr_ok;
    assign hdr_addr = data_in[1:0];
    assign hdr_cnt  = {1'b0, data_in[LEN_MSB:LEN_LSB]} + 7'd1;
    assign hdr_ok   = (hdr_addr != ADDR_INVALID);

    // The output register holds while its target FIFO is full.
    logic stall;
    assign stall = (|write_enb) && full_pad[addr];

    logic accept, hdr_take, load_take, last;
    assign accept    = pkt_valid && !busy;
    assign hdr_take  = (state == IDLE) && accept && hdr_ok;
    assign load_take = (state == LOAD) && accept;
    assign last      = (cnt == 7'd1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = hdr_ok ? LOAD : DROP;
            LOAD:    if (accept && last) state_nxt = CHECK;
            CHECK:   if (!stall) state_nxt = IDLE;
            DROP:    if (accept && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; during reset nothing is taken, so busy and lfd_state stay low.
    always_comb begin
        busy = 1'b0;
        case (state)
            IDLE:    busy = pkt_valid && hdr_ok && !empty_pad[hdr_addr];
            LOAD:    busy = stall;
            CHECK:   busy = 1'b1;
            DROP:    busy = 1'b0;
            default: busy = 1'b0;
        endcase
        if (rst) busy = 1'b0;
    end

    assign lfd_state = hdr_take && !rst;

    // Datapath: address, byte count and the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            cnt       <= '0;
            write_enb <= '0;
            data_out  <= '0;
        end else begin
            if (state == IDLE && accept) begin
                cnt <= hdr_cnt;
            end else if ((state == LOAD || state == DROP) && accept && cnt != 7'd0) begin
                cnt <= cnt - 7'd1;
            end

            if (hdr_take) addr <= hdr_addr;

            if (!stall) begin
                if (hdr_take) begin
                    write_enb <= port_onehot(hdr_addr);
                    data_out  <= data_in;
                end else if (load_take) begin
                    write_enb <= port_onehot(addr);
                    data_out  <= data_in;
                end else begin
                    write_enb <= '0;
                end
            end
        end
    end

`ifdef ROUTER_PARITY_CHECK_EN
    logic par_mismatch;

    router_parity u_parity (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == CHECK),
        .seed       (hdr_take),
        .accumulate (load_take && !last),
        .data_in    (data_in),
        .mismatch   (par_mismatch)
    );

    // Captured when the parity byte (count 1) is taken; cleared by the next valid header.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (hdr_take) begin
            err <= 1'b0;
        end else if (load_take && last) begin
            err <= par_mismatch;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
